case_9_mul_arbiter: RTL and testbench
=====================================

# case_9_mul_arbiter

Round-robin arbiter that shares one signed 11s×7s→11 multiplier core among NUM_REQ independent requesters. Each requester presents operands with a valid/ready handshake. The block grants at most one request per cycle and drives the product, tagged with the requester index, through a single registered response channel. It sits between the HLS-generated compute lanes of case_9 and its shared multiplier resource, so the lanes can time-multiplex one DSP instead of instantiating one each.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- A_W, 11: signed operand A width.
- B_W, 7: signed operand B width.
- P_W, 11: result width.
- ID_W, $clog2(NUM_REQ): response tag width.

- ap_clk, in, 1: single clock; all state is updated on the rising edge.
- ap_rst_n, in, 1: asynchronous, active-low reset.
- req_valid, in, NUM_REQ: per-requester request valid.
- req_ready, out, NUM_REQ: per-requester accept; at most one bit is high per cycle.
- req_a, in, NUM_REQ*A_W: packed operand A; requester i occupies [i*A_W +: A_W].
- req_b, in, NUM_REQ*B_W: packed operand B; requester i occupies [i*B_W +: B_W].
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: downstream accept.
- rsp_id, out, ID_W: index of the requester that owns rsp_data.
- rsp_data, out, P_W: signed product.
- busy, out, 1: high while rsp_valid is high or any req_valid is high.

## Operation
- Arbitration: round-robin pointer rr_ptr. Priority search starts at rr_ptr and wraps modulo NUM_REQ. The winner is the first i with req_valid[i]=1.
- Issue condition: can_issue = !rsp_valid || rsp_ready. The output register is empty, or it is being drained this cycle.
- req_ready[winner] = can_issue. All other req_ready bits are 0.
- req_ready depends combinationally on req_valid and rsp_ready (Mealy). Requesters must not make req_valid depend on req_ready.
- On accept (req_valid[w] && req_ready[w]):
  - rsp_data ← product of sign-extended req_a[w] and req_b[w], formed at full 18-bit width and then reduced to P_W (see Configuration).
  - rsp_id ← w.
  - rsp_valid ← 1.
  - rr_ptr ← (w+1) mod NUM_REQ.
- No accept and rsp_ready=1: rsp_valid ← 0. rsp_data and rsp_id hold their last values.
- rsp_valid=1 and rsp_ready=0: rsp_valid, rsp_data and rsp_id hold. No req_ready is asserted. Requesters stall.
- rr_ptr changes only on an accept. Idle cycles do not rotate priority.
- A requester that drops req_valid before it is granted loses nothing. No request is latched before acceptance.
- Multiplication uses the shared multiplier core as a combinational sub-unit. The only pipeline register is the response register.

## Timing
- Reset: rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0.
- During reset: req_ready=0 and busy reflects only req_valid.
- Latency: a request accepted at edge t gives rsp_valid=1 in the cycle after edge t, i.e. one cycle.
- Throughput: one product per cycle while rsp_ready is held high and at least one requester is valid.
- Simultaneous drain and issue: when rsp_valid=1, rsp_ready=1 and a request is accepted in the same cycle, the register reloads without a bubble.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,…,NUM_REQ-1,0,…. Any valid requester is granted within NUM_REQ accepts.
- Reset asserted mid-operation: the pending response is discarded immediately (asynchronous). After release, arbitration restarts at requester 0.
- Reset release: ap_rst_n is synchronised by the system. The first accept can occur in the first cycle after deassertion.

## Configuration
- CASE_9_MUL_ARB_SAT_EN undefined: the result is the low P_W bits of the 18-bit product. This is two's-complement wrap, bit-exact with the existing 11-bit multiplier.
- CASE_9_MUL_ARB_SAT_EN defined: the 18-bit product is saturated to [-1024, 1023] for P_W=11, generally [-2^(P_W-1), 2^(P_W-1)-1].
- The saturation logic sits between the core and the response register. Latency is unchanged.

## Structure
- Shared package case_9_mul_arb_pkg holds:
  - the A_W, B_W and P_W defaults;
  - the full product width constant PROD_W = A_W+B_W;
  - the saturation bound constants;
  - a function that reduces a PROD_W product to P_W (wrap or saturate, selected by the macro).
- Sub-module case_9_rr_arb holds the round-robin pointer and the priority mask/search. Its inputs are req_valid, can_issue and ap_clk/ap_rst_n. Its outputs are the one-hot grant and the encoded winner index.
- The top instantiates case_9_rr_arb and one instance of the existing 11s×7s→11 multiplier core.

## Test plan
- Reset, then req 0 with a=3, b=-5: rsp_valid one cycle after accept, rsp_data=-15, rsp_id=0.
- Wrap check with the macro undefined: a=1023, b=63 → rsp_data=961, and a=-1024, b=-64 → rsp_data=0.
- Saturation check with CASE_9_MUL_ARB_SAT_EN defined: the same operands as the wrap check both give rsp_data=1023. a=-1024, b=63 → rsp_data=-1024.
- All 4 requesters continuously valid with rsp_ready=1 for 8 accepts → rsp_id sequence 0,1,2,3,0,1,2,3, with no bubbles.
- rsp_ready=0 for 3 cycles while responses are pending → rsp_data and rsp_id are stable and all req_ready=0. On release, the next grant goes to rr_ptr.
- ap_rst_n pulsed low while rsp_valid=1 and req 2 is being accepted → rsp_valid drops immediately. After release, requesters 1 and 2 both valid → requester 1 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/case_9_mul_arb_pkg.sv
// Shared constants and product reduction for the case_9 multiplier arbiter.
// Holds the default operand/result widths, the full product width, the
// saturation bounds and reduce_prod(), which narrows a full-width product to
// the result width.
// Configuration macro: CASE_9_MUL_ARB_SAT_EN
//   undefined -> two's-complement wrap (low result bits of the product)
//   defined   -> saturate to [-2^(P_W-1), 2^(P_W-1)-1]
package case_9_mul_arb_pkg;

  localparam int unsigned DEF_A_W = 11;
  localparam int unsigned DEF_B_W = 7;
  localparam int unsigned DEF_P_W = 11;
  localparam int unsigned PROD_W  = DEF_A_W + DEF_B_W;

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (DEF_P_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (DEF_P_W - 1)));

  function automatic logic signed [DEF_P_W-1:0] reduce_prod(
    input logic signed [PROD_W-1:0] p
  );
`ifdef CASE_9_MUL_ARB_SAT_EN
    if (p > SAT_MAX) begin
      return SAT_MAX[DEF_P_W-1:0];
    end else if (p < SAT_MIN) begin
      return SAT_MIN[DEF_P_W-1:0];
    end else begin
      return p[DEF_P_W-1:0];
    end
`else
    return p[DEF_P_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/case_9_mul_core.sv
// Combinational signed multiplier core (A_W signed x B_W signed).
// Ports:
//   a, b : signed operands
//   p    : full-width signed product (A_W+B_W bits, never overflows)
module case_9_mul_core #(
  parameter int unsigned A_W = 11,
  parameter int unsigned B_W = 7
) (
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  output logic signed [A_W+B_W-1:0] p
);

  // All operands signed, so both are sign-extended to the product width.
  assign p = a * b;

endmodule

// File: rtl/case_9_rr_arb.sv
// Round-robin arbiter: priority search starts at rr_ptr and wraps modulo
// NUM_REQ. The pointer advances to winner+1 only when a grant is issued.
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   req_valid        : per-requester valid
//   can_issue        : output register can accept a new product this cycle
//   grant            : one-hot grant (all zero when nothing can issue)
//   winner           : encoded index of the highest-priority valid requester
module case_9_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               can_issue,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] rr_ptr;
  logic            found;
  int unsigned     idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
    // Grant is qualified by can_issue so a stalled response blocks all ready.
    if (found && can_issue) begin
      grant[winner] = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      if (winner == ID_W'(NUM_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= winner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/case_9_mul_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters.
// One grant per cycle; the product, tagged with the requester index, is held
// in a single registered response channel (one-cycle latency, full
// throughput, reload without bubble on simultaneous drain and issue).
// Configuration macro: CASE_9_MUL_ARB_SAT_EN (saturate instead of wrap).
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   req_valid/ready  : per-requester handshake (ready is Mealy on valid)
//   req_a, req_b     : packed operands, requester i at [i*W +: W]
//   rsp_valid/ready  : response handshake
//   rsp_id, rsp_data : owning requester index and signed product
//   busy             : response pending or any request valid
module case_9_mul_arbiter
  import case_9_mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = DEF_A_W,
  parameter int unsigned B_W     = DEF_B_W,
  parameter int unsigned P_W     = DEF_P_W,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_data,
  output logic                   busy
);

  logic                     can_issue;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          winner;
  logic signed [A_W-1:0]    a_sel;
  logic signed [B_W-1:0]    b_sel;
  logic signed [A_W+B_W-1:0] prod;

  // ap_rst_n term keeps req_ready low while reset is held.
  assign can_issue = ap_rst_n & (~rsp_valid | rsp_ready);
  assign req_ready = grant;
  assign busy      = rsp_valid | (|req_valid);

  assign a_sel = req_a[winner*A_W +: A_W];
  assign b_sel = req_b[winner*B_W +: B_W];

  case_9_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .can_issue (can_issue),
    .grant     (grant),
    .winner    (winner)
  );

  case_9_mul_core #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mul (
    .a (a_sel),
    .b (b_sel),
    .p (prod)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (|grant) begin
      rsp_valid <= 1'b1;
      rsp_data  <= reduce_prod(prod);
      rsp_id    <= winner;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_case_9_mul_arbiter.sv
module tb_case_9_mul_arbiter;

  localparam int NR = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*11-1:0] req_a = '0;
  logic [NR*7-1:0]  req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_id;
  logic [10:0]   rsp_data;
  logic          busy;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  int ptr = 0;
  int m_valid = 0;
  int m_data = 0;
  int m_id = 0;
  int ta[NR];
  int tb[NR];

  always #5 ap_clk = ~ap_clk;

  case_9_mul_arbiter #(
    .NUM_REQ (4),
    .A_W     (11),
    .B_W     (7),
    .P_W     (11),
    .ID_W    (2)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_mul(input int a, input int b);
    int p;
    int w;
    p = a * b;
`ifdef CASE_9_MUL_ARB_SAT_EN
    if (p > 1023) return 1023;
    if (p < -1024) return -1024;
    return p;
`else
    w = p & 2047;
    if (w >= 1024) w = w - 2048;
    return w;
`endif
  endfunction

  function automatic int rnd_a();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  function automatic int rnd_b();
    return int'($urandom_range(0, 127)) - 64;
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*11 +: 11] = ta[i][10:0];
      req_b[i*7 +: 7]   = tb[i][6:0];
    end
  endtask

  task automatic model_reset();
    ptr = 0; m_valid = 0; m_data = 0; m_id = 0;
  endtask

  // Called at a falling edge: drive, check Mealy outputs, advance one cycle,
  // check registered outputs at the next falling edge.
  task automatic step(input logic [NR-1:0] v, input logic rr);
    int win;
    int can;
    int exp_ready;
    req_valid = v;
    rsp_ready = rr;
    pack_ops();
    #1;
    can = (m_valid == 0) || rr;
    win = -1;
    for (int k = 0; k < NR; k++) begin
      if (win < 0 && v[(ptr + k) % NR]) win = (ptr + k) % NR;
    end
    exp_ready = (can != 0 && win >= 0) ? (1 << win) : 0;
    check_val("req_ready", int'(req_ready), exp_ready);
    check_val("busy", int'(busy), (m_valid != 0 || v != '0) ? 1 : 0);
    @(posedge ap_clk);
    if (exp_ready != 0) begin
      m_valid = 1;
      m_data  = ref_mul(ta[win], tb[win]);
      m_id    = win;
      ptr     = (win + 1) % NR;
    end else if (rr) begin
      m_valid = 0;
    end
    @(negedge ap_clk);
    check_val("rsp_valid", int'(rsp_valid), m_valid);
    check_val("rsp_data", int'($signed(rsp_data)), m_data);
    check_val("rsp_id", int'(rsp_id), m_id);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      ta[i] = 0;
      tb[i] = 0;
    end

    // reset state, req_ready held low and busy follows req_valid during reset
    @(negedge ap_clk);
    req_valid = 4'hf;
    rsp_ready = 1'b1;
    #1;
    check_val("rst_rsp_valid", int'(rsp_valid), 0);
    check_val("rst_rsp_data", int'(rsp_data), 0);
    check_val("rst_rsp_id", int'(rsp_id), 0);
    check_val("rst_req_ready", int'(req_ready), 0);
    check_val("rst_busy_on", int'(busy), 1);
    req_valid = '0;
    #1;
    check_val("rst_busy_off", int'(busy), 0);
    do_reset();

    // basic product
    ta[0] = 3; tb[0] = -5;
    step(4'b0001, 1'b1);
    check_val("basic_data", int'($signed(rsp_data)), -15);
    check_val("basic_id", int'(rsp_id), 0);

    // wrap / saturate corners
    ta[0] = 1023; tb[0] = 63;
    step(4'b0001, 1'b1);
`ifdef CASE_9_MUL_ARB_SAT_EN
    check_val("corner_pos", int'($signed(rsp_data)), 1023);
`else
    check_val("corner_pos", int'($signed(rsp_data)), 961);
`endif
    ta[0] = -1024; tb[0] = -64;
    step(4'b0001, 1'b1);
`ifdef CASE_9_MUL_ARB_SAT_EN
    check_val("corner_negneg", int'($signed(rsp_data)), 1023);
`else
    check_val("corner_negneg", int'($signed(rsp_data)), 0);
`endif
    ta[0] = -1024; tb[0] = 63;
    step(4'b0001, 1'b1);
    check_val("corner_neg", int'($signed(rsp_data)), -1024);

    // fairness: all valid, no bubbles, ids 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < NR; i++) begin
      ta[i] = rnd_a();
      tb[i] = rnd_b();
    end
    for (int k = 0; k < 8; k++) begin
      step(4'hf, 1'b1);
      check_val("fair_id", int'(rsp_id), k % NR);
      check_val("fair_valid", int'(rsp_valid), 1);
    end

    // stall: response held, no ready, then grant goes to pointer (0)
    for (int k = 0; k < 3; k++) step(4'hf, 1'b0);
    step(4'hf, 1'b1);
    check_val("stall_release_id", int'(rsp_id), 0);

    // asynchronous reset while a response is pending and req 2 accepted
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    ta[2] = 5; tb[2] = 7;
    pack_ops();
    #1;
    check_val("mid_ready", int'(req_ready), 4);
    @(posedge ap_clk);
    #1;
    check_val("mid_valid", int'(rsp_valid), 1);
    check_val("mid_id", int'(rsp_id), 2);
    check_val("mid_data", int'($signed(rsp_data)), 35);
    ap_rst_n = 1'b0;
    #1;
    check_val("arst_valid", int'(rsp_valid), 0);
    check_val("arst_data", int'(rsp_data), 0);
    check_val("arst_ready", int'(req_ready), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    model_reset();
    step(4'b0110, 1'b1);
    check_val("post_rst_id", int'(rsp_id), 1);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        ta[i] = rnd_a();
        tb[i] = rnd_b();
      end
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
